fwd_pipe_unit: RTL and testbench

Parametrised operand-forwarding and writeback-tracking unit for the pipelined MIPS core. It keeps a shadow pipeline of in-flight register writes (MEM, WB and optional further retire stages) and resolves every EX-stage source operand against it, youngest first. It raises a load-use stall when the operand is still in flight from a load, and drives the register-file write port from the oldest slot. It generalises the fixed three-way forwarding mux (none/MEM/WB) to N read ports and DEPTH stages.

---
 rtl/fwd_pkg.sv | 26 ++
 rtl/fwd_port_sel.sv | 55 +++++
 rtl/fwd_pipe_unit.sv | 93 +++++++++
 tb/tb_fwd_pipe_unit.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/fwd_pkg.sv
// Shared encodings and helpers for the operand-forwarding unit.
package fwd_pkg;

  // Select codes: slot k forwards as k+1, so MEM=1, WB=2, later retire stages follow.
  localparam int FWD_NONE = 0;
  localparam int FWD_MEM  = 1;
  localparam int FWD_WB   = 2;

  // Reference widths of the core's default configuration.
  localparam int SLOT_DATA_W = 32;
  localparam int SLOT_ADDR_W = 5;

  // One tracked in-flight register write.
  typedef struct packed {
    logic                   valid;
    logic [SLOT_ADDR_W-1:0] addr;
    logic [SLOT_DATA_W-1:0] data;
    logic                   is_load;
  } fwd_slot_t;

  // Select width needed to encode FWD_NONE plus one code per tracked slot.
  function automatic int fwd_sel_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fwd_port_sel.sv
// Priority match of one EX source operand against the shadow pipeline.
module fwd_port_sel import fwd_pkg::*; #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int DEPTH  = 2,
  parameter int SEL_W  = fwd_sel_w(DEPTH)
) (
  input  logic [REG_AW-1:0]             rs_addr,
  input  logic [DATA_W-1:0]             rs_rd,
  input  logic [DEPTH-1:0]              slot_vld,
  input  logic [DEPTH-1:0][REG_AW-1:0]  slot_addr,
  input  logic [DEPTH-1:0][DATA_W-1:0]  slot_data,
  input  logic                          slot0_load,
  output logic [SEL_W-1:0]              sel,
  output logic [DATA_W-1:0]             opnd,
  output logic                          load_hit
);

  logic              hit;
  logic              win_load;
  logic [SEL_W-1:0]  win_sel;
  logic [DATA_W-1:0] win_data;

  // Scan oldest to youngest so the youngest matching slot overwrites the winner.
  always_comb begin
    hit      = 1'b0;
    win_load = 1'b0;
    win_sel  = SEL_W'(FWD_NONE);
    win_data = rs_rd;
    for (int k = DEPTH-1; k >= 0; k--) begin
      if (rs_addr != '0 && slot_vld[k] && slot_addr[k] == rs_addr) begin
        hit      = 1'b1;
        win_load = (k == 0) && slot0_load;
        win_sel  = SEL_W'(k + 1);
        win_data = slot_data[k];
      end
    end
  end

  // A load still in MEM has no data yet: report the hazard instead of forwarding.
  always_comb begin
    sel      = SEL_W'(FWD_NONE);
    opnd     = rs_rd;
    load_hit = 1'b0;
    if (hit) begin
      if (win_load) begin
        load_hit = 1'b1;
      end else begin
        sel  = win_sel;
        opnd = win_data;
      end
    end
  end

endmodule

// File: rtl/fwd_pipe_unit.sv
// Shadow pipeline of in-flight register writes with N-port operand forwarding,
// load-use hazard detection and register-file writeback from the oldest slot.
module fwd_pipe_unit import fwd_pkg::*; #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int NUM_RD = 2,
  parameter int DEPTH  = 2,
  parameter int SEL_W  = fwd_sel_w(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ex_hold,
  input  logic                     ex_flush,
  input  logic                     ex_wr_en,
  input  logic [REG_AW-1:0]        ex_wr_addr,
  input  logic [DATA_W-1:0]        ex_wr_data,
  input  logic                     ex_is_load,
  input  logic [DATA_W-1:0]        mem_load_data,
  input  logic [NUM_RD*REG_AW-1:0] ex_rs_addr,
  input  logic [NUM_RD*DATA_W-1:0] ex_rs_rd,
  output logic [NUM_RD*DATA_W-1:0] ex_opnd,
  output logic [NUM_RD*SEL_W-1:0]  fwd_sel,
  output logic                     load_use_stall,
  output logic                     wb_wr_en,
  output logic [REG_AW-1:0]        wb_wr_addr,
  output logic [DATA_W-1:0]        wb_wr_data
);

  localparam int STAGES = DEPTH - 1;

  // Slot k = index k: 0 is MEM, 1 is WB, higher indices are later retire stages.
  logic [STAGES:0]             vld_pipe;
  logic [STAGES:0][REG_AW-1:0] addr_pipe;
  logic [STAGES:0][DATA_W-1:0] data_pipe;
  // Only slot0 needs the load flag; from slot1 on the load data is already captured.
  logic                        ld0;
  logic [NUM_RD-1:0]           load_hit;
  logic                        slot0_in_vld;

  assign load_use_stall = |load_hit;
  // Flushed, stalled (bubble) and r0 writes never become visible.
  assign slot0_in_vld   = ex_wr_en & ~ex_flush & ~load_use_stall & (ex_wr_addr != '0);

  // Advance the shadow pipeline unless the whole pipe is frozen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe  <= '0;
      addr_pipe <= '0;
      data_pipe <= '0;
      ld0       <= 1'b0;
    end else if (!ex_hold) begin
      vld_pipe     <= {vld_pipe[STAGES-1:0], slot0_in_vld};
      addr_pipe    <= {addr_pipe[STAGES-1:0], ex_wr_addr};
      data_pipe[0] <= ex_wr_data;
      data_pipe[1] <= ld0 ? mem_load_data : data_pipe[0];
      for (int k = 2; k <= STAGES; k++)
        data_pipe[k] <= data_pipe[k-1];
      ld0          <= ex_is_load;
    end
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_port
    logic [SEL_W-1:0]  sel;
    logic [DATA_W-1:0] opnd;

    fwd_port_sel #(
      .DATA_W (DATA_W),
      .REG_AW (REG_AW),
      .DEPTH  (DEPTH),
      .SEL_W  (SEL_W)
    ) u_sel (
      .rs_addr    (ex_rs_addr[p*REG_AW +: REG_AW]),
      .rs_rd      (ex_rs_rd[p*DATA_W +: DATA_W]),
      .slot_vld   (vld_pipe),
      .slot_addr  (addr_pipe),
      .slot_data  (data_pipe),
      .slot0_load (ld0),
      .sel        (sel),
      .opnd       (opnd),
      .load_hit   (load_hit[p])
    );

    assign ex_opnd[p*DATA_W +: DATA_W] = opnd;
    assign fwd_sel[p*SEL_W +: SEL_W]   = sel;
  end

  // The oldest slot drives the register-file write port; it stays forwardable
  // because the file only updates on this same edge.
  assign wb_wr_en   = vld_pipe[STAGES];
  assign wb_wr_addr = addr_pipe[STAGES];
  assign wb_wr_data = data_pipe[STAGES];

endmodule

// File: tb/tb_fwd_pipe_unit.sv
// Table-driven bench for fwd_pipe_unit (DEPTH=3, NUM_RD=3) with a writeback scoreboard.
module tb_fwd_pipe_unit;

  localparam int DW = 32, AW = 5, NRD = 3, DEP = 3, SW = 2;
  localparam logic [31:0] R0 = 32'h0000_A000, R1 = 32'h0000_A001, R2 = 32'h0000_A002;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                ex_hold, ex_flush, ex_wr_en, ex_is_load;
  logic [AW-1:0]       ex_wr_addr;
  logic [DW-1:0]       ex_wr_data, mem_load_data;
  logic [NRD*AW-1:0]   ex_rs_addr;
  logic [NRD*DW-1:0]   ex_rs_rd;
  logic [NRD*DW-1:0]   ex_opnd;
  logic [NRD*SW-1:0]   fwd_sel;
  logic                load_use_stall, wb_wr_en;
  logic [AW-1:0]       wb_wr_addr;
  logic [DW-1:0]       wb_wr_data;

  fwd_pipe_unit #(.DATA_W(DW), .REG_AW(AW), .NUM_RD(NRD), .DEPTH(DEP)) dut (
    .clk(clk), .rst_n(rst_n), .ex_hold(ex_hold), .ex_flush(ex_flush),
    .ex_wr_en(ex_wr_en), .ex_wr_addr(ex_wr_addr), .ex_wr_data(ex_wr_data),
    .ex_is_load(ex_is_load), .mem_load_data(mem_load_data),
    .ex_rs_addr(ex_rs_addr), .ex_rs_rd(ex_rs_rd), .ex_opnd(ex_opnd),
    .fwd_sel(fwd_sel), .load_use_stall(load_use_stall),
    .wb_wr_en(wb_wr_en), .wb_wr_addr(wb_wr_addr), .wb_wr_data(wb_wr_data)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic            h, f, w;
    logic [4:0]      wa;
    logic [31:0]     wd;
    logic            ld;
    logic [31:0]     lt;
    logic [2:0][4:0] ra;
    logic [2:0][1:0] es;
    logic [2:0][31:0] eo;
    logic [2:0]      om;   // which ports have a defined operand to check
    logic            st;
    logic            wb;
  } vec_t;

  typedef struct packed { logic [4:0] addr; logic [31:0] data; } wb_t;

  int   n_chk = 0, n_fail = 0;
  wb_t  exp_q[$];
  wb_t  mon_e;
  logic cur_stall = 1'b0;
  logic last_adv;
  logic pend_v, pend_ld;
  logic [4:0]  pend_a;
  logic [31:0] pend_d;
  vec_t tbl[29];
  vec_t hv;

  function automatic vec_t mk(input int h, f, w, wa, wd, ld, lt, a0, a1, a2,
                              s0, s1, s2, o0, o1, o2, om, st, wb);
    vec_t v;
    v.h = 1'(h); v.f = 1'(f); v.w = 1'(w); v.wa = 5'(wa); v.wd = 32'(wd);
    v.ld = 1'(ld); v.lt = 32'(lt);
    v.ra[0] = 5'(a0); v.ra[1] = 5'(a1); v.ra[2] = 5'(a2);
    v.es[0] = 2'(s0); v.es[1] = 2'(s1); v.es[2] = 2'(s2);
    v.eo[0] = 32'(o0); v.eo[1] = 32'(o1); v.eo[2] = 32'(o2);
    v.om = 3'(om); v.st = 1'(st); v.wb = 1'(wb);
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Apply one vector after the rising edge, then check combinational outputs at the falling edge.
  task automatic step(input int idx, input vec_t v);
    @(posedge clk); #1;
    ex_hold = v.h; ex_flush = v.f; ex_wr_en = v.w; ex_wr_addr = v.wa;
    ex_wr_data = v.wd; ex_is_load = v.ld; mem_load_data = v.lt;
    ex_rs_addr = v.ra; cur_stall = v.st;
    @(negedge clk);
    chk($sformatf("v%0d_stall", idx), 32'(load_use_stall), 32'(v.st));
    chk($sformatf("v%0d_wb_en", idx), 32'(wb_wr_en), 32'(v.wb));
    for (int p = 0; p < NRD; p++) begin
      chk($sformatf("v%0d_sel%0d", idx, p), 32'(fwd_sel[p*SW +: SW]), 32'(v.es[p]));
      if (v.om[p])
        chk($sformatf("v%0d_opnd%0d", idx, p), ex_opnd[p*DW +: DW], v.eo[p]);
    end
  endtask

  // Bench model of the write path: a slot0 stand-in that turns into an expected
  // writeback (with load data substituted) when it advances.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_v   <= 1'b0;
      pend_ld  <= 1'b0;
      pend_a   <= '0;
      pend_d   <= '0;
      last_adv <= 1'b0;
      exp_q.delete();
    end else begin
      last_adv <= !ex_hold;
      if (!ex_hold) begin
        if (pend_v) exp_q.push_back({pend_a, pend_ld ? mem_load_data : pend_d});
        pend_v  <= ex_wr_en && !ex_flush && !cur_stall && (ex_wr_addr != 5'd0);
        pend_a  <= ex_wr_addr;
        pend_d  <= ex_wr_data;
        pend_ld <= ex_is_load;
      end
    end
  end

  // Each newly presented writeback must match the oldest expected write.
  always @(negedge clk) begin
    if (rst_n && wb_wr_en && last_adv) begin
      if (exp_q.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL wb_unexpected: got addr %0d data %h expected no write", wb_wr_addr, wb_wr_data);
      end else begin
        mon_e = exp_q.pop_front();
        chk("wb_addr", 32'(wb_wr_addr), 32'(mon_e.addr));
        chk("wb_data", wb_wr_data, mon_e.data);
      end
    end
  end

  initial begin
    //            h f w wa  wd       ld lt        a0 a1 a2  s0 s1 s2  o0       o1       o2      om st wb
    tbl[0]  = mk(0,0,1, 3,'h11,    0,0,         3, 0, 0,  0, 0, 0,  R0,      R1,      R2,      7,0,0);
    tbl[1]  = mk(0,0,0, 0,0,       0,0,         3, 0, 0,  1, 0, 0,  'h11,    R1,      R2,      7,0,0);
    tbl[2]  = mk(0,0,0, 0,0,       0,0,         3, 3, 0,  2, 2, 0,  'h11,    'h11,    R2,      7,0,0);
    tbl[3]  = mk(0,0,0, 0,0,       0,0,         0, 0, 3,  0, 0, 3,  R0,      R1,      'h11,    7,0,1);
    tbl[4]  = mk(0,0,1, 5,'hA,     0,0,         0, 0, 0,  0, 0, 0,  R0,      R1,      R2,      7,0,0);
    tbl[5]  = mk(0,0,1, 5,'hB,     0,0,         5, 0, 0,  1, 0, 0,  'hA,     R1,      R2,      7,0,0);
    tbl[6]  = mk(0,0,0, 0,0,       0,0,         5, 5, 0,  1, 1, 0,  'hB,     'hB,     R2,      7,0,0);
    tbl[7]  = mk(0,0,0, 0,0,       0,0,         5, 0, 0,  2, 0, 0,  'hB,     R1,      R2,      7,0,1);
    tbl[8]  = mk(0,0,0, 0,0,       0,0,         0, 0, 5,  0, 0, 3,  R0,      R1,      'hB,     7,0,1);
    tbl[9]  = mk(0,0,1, 7,'h7777,  1,0,         0, 0, 0,  0, 0, 0,  R0,      R1,      R2,      7,0,0);
    tbl[10] = mk(0,0,1, 8,'h88,    0,'hDEAD,    7, 7, 0,  0, 0, 0,  R0,      R1,      R2,      4,1,0);
    tbl[11] = mk(0,0,1, 8,'h88,    0,0,         7, 0, 0,  2, 0, 0,  'hDEAD,  R1,      R2,      7,0,0);
    tbl[12] = mk(0,0,0, 0,0,       0,0,         8, 0, 7,  1, 0, 3,  'h88,    R1,      'hDEAD,  7,0,1);
    tbl[13] = mk(0,0,1, 0,'h55,    0,0,         0, 8, 0,  0, 2, 0,  R0,      'h88,    R2,      7,0,0);
    tbl[14] = mk(0,0,0, 0,0,       0,0,         0, 0, 8,  0, 0, 3,  R0,      R1,      'h88,    7,0,1);
    tbl[15] = mk(0,0,1, 9,'h99,    0,0,         0, 0, 0,  0, 0, 0,  R0,      R1,      R2,      7,0,0);
    tbl[16] = mk(1,1,1,10,'hAA,    0,0,         9, 0, 0,  1, 0, 0,  'h99,    R1,      R2,      7,0,0);
    tbl[17] = mk(1,0,0, 0,0,       0,0,         9, 0, 0,  1, 0, 0,  'h99,    R1,      R2,      7,0,0);
    tbl[18] = mk(1,1,0, 0,0,       0,0,         9, 0, 0,  1, 0, 0,  'h99,    R1,      R2,      7,0,0);
    tbl[19] = mk(0,0,0, 0,0,       0,0,         9, 0, 0,  1, 0, 0,  'h99,    R1,      R2,      7,0,0);
    tbl[20] = mk(0,0,0, 0,0,       0,0,         9,10, 0,  2, 0, 0,  'h99,    R1,      R2,      7,0,0);
    tbl[21] = mk(0,1,1,11,'hBB,    0,0,         0, 0, 9,  0, 0, 3,  R0,      R1,      'h99,    7,0,1);
    tbl[22] = mk(0,0,0, 0,0,       0,0,        11, 0, 0,  0, 0, 0,  R0,      R1,      R2,      7,0,0);
    tbl[23] = mk(0,0,1,12,'hC,     1,0,         0, 0, 0,  0, 0, 0,  R0,      R1,      R2,      7,0,0);
    tbl[24] = mk(1,0,0, 0,0,       0,0,        12, 0, 0,  0, 0, 0,  R0,      R1,      R2,      6,1,0);
    tbl[25] = mk(0,1,1,13,'h13,    0,'hBEEF,   12, 0, 0,  0, 0, 0,  R0,      R1,      R2,      6,1,0);
    tbl[26] = mk(0,0,0, 0,0,       0,0,        12, 0, 0,  2, 0, 0,  'hBEEF,  R1,      R2,      7,0,0);
    tbl[27] = mk(0,0,0, 0,0,       0,0,         0,12, 0,  0, 3, 0,  R0,      'hBEEF,  R2,      7,0,1);
    tbl[28] = mk(0,0,0, 0,0,       0,0,         0, 0, 0,  0, 0, 0,  R0,      R1,      R2,      7,0,0);

    ex_rs_rd = {R2, R1, R0};
    ex_hold = 1'b0; ex_flush = 1'b0; ex_wr_en = 1'b0; ex_wr_addr = '0;
    ex_wr_data = '0; ex_is_load = 1'b0; mem_load_data = '0;
    ex_rs_addr = {5'd3, 5'd2, 5'd1};
    rst_n = 1'b0;
    #12;
    chk("rst_wb_en", 32'(wb_wr_en), 32'd0);
    chk("rst_stall", 32'(load_use_stall), 32'd0);
    chk("rst_sel",   32'(fwd_sel), 32'd0);
    for (int p = 0; p < NRD; p++)
      chk($sformatf("rst_opnd%0d", p), ex_opnd[p*DW +: DW], ex_rs_rd[p*DW +: DW]);
    @(negedge clk); rst_n = 1'b1;

    for (int i = 0; i < 29; i++) step(i, tbl[i]);

    // Three ports reading three different in-flight registers.
    step(100, mk(0,0,1, 1,'h101, 0,0, 0,0,0, 0,0,0, R0,R1,R2, 7,0,0));
    step(101, mk(0,0,1, 2,'h202, 0,0, 0,0,0, 0,0,0, R0,R1,R2, 7,0,0));
    step(102, mk(0,0,1, 4,'h404, 0,0, 0,0,0, 0,0,0, R0,R1,R2, 7,0,0));
    step(103, mk(0,0,1, 6,'h66,  1,0, 4,2,1, 1,2,3, 'h404,'h202,'h101, 7,0,1));
    // Load in MEM while port0 needs it: stall, then reset mid-cycle.
    hv = mk(0,0,0, 0,0, 0,'h6666, 6,4,2, 0,2,3, R0,'h404,'h202, 6,1,1);
    step(104, hv);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_stall", 32'(load_use_stall), 32'd0);
    chk("mid_rst_wb_en", 32'(wb_wr_en), 32'd0);
    chk("mid_rst_sel",   32'(fwd_sel), 32'd0);
    for (int p = 0; p < NRD; p++)
      chk($sformatf("mid_rst_opnd%0d", p), ex_opnd[p*DW +: DW], ex_rs_rd[p*DW +: DW]);
    @(negedge clk); rst_n = 1'b1;
    step(105, mk(0,0,0, 0,0, 0,0, 6,4,2, 0,0,0, R0,R1,R2, 7,0,0));
    step(106, mk(0,0,0, 0,0, 0,0, 0,0,0, 0,0,0, R0,R1,R2, 7,0,0));
    @(negedge clk);
    chk("wb_queue_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
